// File: rtl/sdrahb_ram_rd_streamer.sv
// sdrahb_ram_rd_streamer
// Reads a burst of consecutive words from a synchronous-read RAM and streams
// them out on a valid/ready interface. A 3-entry FIFO absorbs the one-cycle
// RAM latency so that back-pressure never loses a word.
// Optional feature: define SDRAHB_RD_ABORT_EN to add an 'abort' input that
// cancels a running burst.
module sdrahb_ram_rd_streamer #(
  parameter int MEM_DEPTH  = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
`ifdef SDRAHB_RD_ABORT_EN
  input  logic                  abort,
`endif
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  state_t                state;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  in_flight;

  // Shift-style FIFO: entry 0 is the head and drives the stream directly.
  logic [DATA_WIDTH-1:0] fifo_data [3];
  logic [2:0]            fifo_vld;
  logic [DATA_WIDTH-1:0] fifo_data_nx [3];
  logic [2:0]            fifo_vld_nx;

  logic [1:0]            occ;
  logic [1:0]            occ_after_pop;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic                  abort_hit;
  logic                  last_xfer;

  assign out_data  = fifo_data[0];
  assign out_valid = fifo_vld[0];

  // Control decode: occupancy, handshake and read-issue decisions.
  always_comb begin
    occ           = {1'b0, fifo_vld[0]} + {1'b0, fifo_vld[1]} + {1'b0, fifo_vld[2]};
    pop           = fifo_vld[0] & out_ready;
    push          = in_flight;
    occ_after_pop = occ - {1'b0, pop};
    // Issue only when the FIFO is guaranteed room for the returning word,
    // even if nothing is popped in the meantime.
    issue         = (state == READ) &&
                    (({1'b0, occ} + {2'b00, in_flight}) <= 3'd2);
    last_xfer     = (state == DRAIN) && pop && (occ == 2'd1) && !in_flight;
`ifdef SDRAHB_RD_ABORT_EN
    abort_hit     = abort && (state != IDLE);
`else
    abort_hit     = 1'b0;
`endif
  end

  // FIFO next-state: pop shifts toward the head, push fills the first free slot.
  always_comb begin
    fifo_data_nx = fifo_data;
    fifo_vld_nx  = fifo_vld;
    if (pop) begin
      fifo_data_nx[0] = fifo_data[1];
      fifo_data_nx[1] = fifo_data[2];
      fifo_vld_nx     = {1'b0, fifo_vld[2:1]};
    end else begin
      fifo_vld_nx     = fifo_vld;
    end
    if (push) begin
      case (occ_after_pop)
        2'd0: begin
          fifo_data_nx[0] = ram_rd_data;
          fifo_vld_nx[0]  = 1'b1;
        end
        2'd1: begin
          fifo_data_nx[1] = ram_rd_data;
          fifo_vld_nx[1]  = 1'b1;
        end
        2'd2: begin
          fifo_data_nx[2] = ram_rd_data;
          fifo_vld_nx[2]  = 1'b1;
        end
        default: begin
          fifo_vld_nx = fifo_vld_nx;
        end
      endcase
    end else begin
      fifo_vld_nx = fifo_vld_nx;
    end
    if (abort_hit) begin
      fifo_vld_nx = 3'b000;
    end else begin
      fifo_vld_nx = fifo_vld_nx;
    end
  end

  // FIFO storage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        fifo_data[i] <= {DATA_WIDTH{1'b0}};
      end
      fifo_vld <= 3'b000;
    end else begin
      fifo_data <= fifo_data_nx;
      fifo_vld  <= fifo_vld_nx;
    end
  end

  // Burst FSM: address generation, remaining count, in-flight tracking, busy/done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ram_rd_addr <= {ADDR_WIDTH{1'b0}};
      remaining   <= {(ADDR_WIDTH+1){1'b0}};
      in_flight   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          in_flight <= 1'b0;
          if (start && (length != {(ADDR_WIDTH+1){1'b0}})) begin
            state       <= READ;
            ram_rd_addr <= start_addr;
            remaining   <= length;
            busy        <= 1'b1;
          end else if (start) begin
            // Empty burst: acknowledge without moving any data.
            done <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        READ: begin
          if (abort_hit) begin
            state     <= IDLE;
            in_flight <= 1'b0;
            remaining <= {(ADDR_WIDTH+1){1'b0}};
            busy      <= 1'b0;
          end else begin
            in_flight <= issue;
            if (issue) begin
              ram_rd_addr <= (ram_rd_addr == LAST_ADDR) ? {ADDR_WIDTH{1'b0}}
                                                        : ram_rd_addr + 1'b1;
              remaining   <= remaining - 1'b1;
              if (remaining == {{ADDR_WIDTH{1'b0}}, 1'b1}) begin
                state <= DRAIN;
              end else begin
                state <= READ;
              end
            end else begin
              state <= READ;
            end
          end
        end
        DRAIN: begin
          in_flight <= 1'b0;
          if (abort_hit) begin
            state     <= IDLE;
            remaining <= {(ADDR_WIDTH+1){1'b0}};
            busy      <= 1'b0;
          end else if (last_xfer) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= DRAIN;
          end
        end
        default: begin
          state     <= IDLE;
          in_flight <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sdrahb_ram_rd_streamer.md
SDRAHB_RAM_RD_STREAMER -- requirements
Module: sdrahb_ram_rd_streamer

Interface
REQ-001 Parameter MEM_DEPTH, default 1024, words in the attached RAM block.
REQ-002 Parameter ADDR_WIDTH, default 10, RAM address width.
REQ-003 Parameter DATA_WIDTH, default 32, RAM word width.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset, with ports as listed below.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  burst request, sampled only in IDLE.
REQ-008 start_addr  input  ADDR_WIDTH  first word address.
REQ-009 length  input  ADDR_WIDTH+1  word count; 0 means empty burst.
REQ-010 ram_rd_addr  output  ADDR_WIDTH  drives RAM read address.
REQ-011 ram_rd_data  input  DATA_WIDTH  RAM read data, valid one edge after address.
REQ-012 out_data  output  DATA_WIDTH  stream data.
REQ-013 out_valid  output  1  stream valid.
REQ-014 out_ready  input  1  stream ready; transfer when out_valid and out_ready are both high.
REQ-015 busy  output  1  burst in progress.
REQ-016 done  output  1  one-cycle pulse at burst completion.

Function
REQ-017 States SHALL be IDLE, READ and DRAIN.
- IDLE->READ: start=1, length!=0.
- READ->DRAIN: last address issued.
- DRAIN->IDLE: last word transferred.
REQ-018 If start=1 and length=0 in IDLE, the block SHALL stay in IDLE, pulse done the next cycle, and emit no data.
REQ-019 On start acceptance, ram_rd_addr SHALL load start_addr and an internal remaining-count register SHALL load length.
REQ-020 Issue condition SHALL be: state READ, and (buffer occupancy + in-flight reads) <= 2.
REQ-021 Each issue SHALL increment ram_rd_addr and decrement the remaining count; address MEM_DEPTH-1 SHALL wrap to 0.
REQ-022 Issued reads SHALL be tracked with a one-bit in-flight register; returning ram_rd_data SHALL be written into a 3-entry FIFO on the following edge.
REQ-023 out_data and out_valid SHALL come directly from the FIFO head registers, with no combinational path from ram_rd_data.
REQ-024 Latency: out_valid SHALL first rise 2 cycles after the start-sampling edge (e.g. start sampled at edge E0 gives out_valid=1 after E2).
REQ-025 With out_ready held high, throughput SHALL be one word per cycle.
REQ-026 out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-027 Simultaneous FIFO push and pop SHALL leave occupancy unchanged, and the FIFO SHALL never overflow.
REQ-028 Words SHALL be delivered in address order, including across the wrap.
REQ-029 busy SHALL be 1 in READ and DRAIN, and 0 in IDLE.
REQ-030 done SHALL pulse in the cycle after the final transfer, coincident with the return to IDLE.
REQ-031 start asserted while busy SHALL be ignored.

Reset
REQ-032 While rst=1, the block SHALL force state IDLE and clear FIFO occupancy, in-flight flag and remaining count.
REQ-033 While rst=1, outputs SHALL be ram_rd_addr=0, out_data=0, out_valid=0, busy=0, done=0.
REQ-034 Reset mid-burst SHALL discard all buffered and in-flight data, and no done pulse SHALL follow.

Configuration
REQ-035 Macro SDRAHB_RD_ABORT_EN SHALL control an abort feature.
REQ-036 With SDRAHB_RD_ABORT_EN defined, input port abort (1 bit) SHALL exist.
- abort=1 in READ or DRAIN: flush the FIFO and drop the in-flight read.
- Enter IDLE at the next edge.
- out_valid=0 and busy=0 after that edge; no done pulse.
- Ignored in IDLE.
REQ-037 Without SDRAHB_RD_ABORT_EN, the abort port and its logic SHALL be absent; bursts end only by completion or reset.

Verification
REQ-038 RAM preloaded mem[i]=i; start_addr=5, length=4, out_ready=1 -> out_valid high for 4 consecutive cycles from start+2, data 5,6,7,8, then done pulse, busy=0.
REQ-039 MEM_DEPTH=1024; start_addr=1022, length=4 -> data 1022,1023,0,1 in order.
REQ-040 length=4; out_ready toggles 1,0,0,1,... -> no loss or duplication, out_data stable during stalls, FIFO occupancy never exceeds 3.
REQ-041 length=0 -> done pulse the next cycle, out_valid never asserted, busy stays 0.
REQ-042 rst pulsed after the second word of a length-8 burst -> all outputs 0; new burst start_addr=0, length=2 -> data 0,1.
REQ-043 With SDRAHB_RD_ABORT_EN, abort asserted after the first word of a length-8 burst -> out_valid=0 and busy=0 next cycle, no done pulse.
